// File: rtl/adc_capture.sv
// adc_capture: arms under the control state, waits for an optional rising
// level trigger, then stores eight 12-bit ADC samples (optionally decimated)
// into a register bank presented as eight parallel datapoint outputs.
module adc_capture #(
  parameter int DECIM = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  controlstate,
  input  logic [11:0] adcIn,
  input  logic        adcValid,
  input  logic        trigEn,
  input  logic [11:0] trigLevel,
  output logic [11:0] capDP0,
  output logic [11:0] capDP1,
  output logic [11:0] capDP2,
  output logic [11:0] capDP3,
  output logic [11:0] capDP4,
  output logic [11:0] capDP5,
  output logic [11:0] capDP6,
  output logic [11:0] capDP7,
  output logic [3:0]  capCount,
  output logic        capBusy,
  output logic        capDone
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FILL  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] CS_ARM     = 4'h6;
  localparam logic [3:0] CS_RUN     = 4'h8;
  localparam logic [3:0] DECIM_LAST = 4'(DECIM - 1);

  state_t      state_q, state_d;
  logic [11:0] dp_q [8];
  logic [11:0] dp_d [8];
  logic [3:0]  count_q, count_d;
  logic [3:0]  decim_q, decim_d;
  logic [11:0] prev_sample_q, prev_sample_d;
  logic        prev_valid_q, prev_valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        trig_fire;

  // Trigger fires immediately when untriggered, else on an upward crossing of the level
  always_comb begin
    trig_fire = !trigEn ||
                (prev_valid_q && (prev_sample_q < trigLevel) && (adcIn >= trigLevel));
  end

  // Next-state logic: ARM restarts everything, RUN advances only on valid samples, anything else holds
  always_comb begin
    state_d       = state_q;
    dp_d          = dp_q;
    count_d       = count_q;
    decim_d       = decim_q;
    prev_sample_d = prev_sample_q;
    prev_valid_d  = prev_valid_q;
    busy_d        = busy_q;
    done_d        = done_q;

    if (controlstate == CS_ARM) begin
      state_d      = ARMED;
      dp_d         = '{default: '0};
      count_d      = '0;
      decim_d      = '0;
      prev_valid_d = 1'b0;
      done_d       = 1'b0;
      busy_d       = 1'b1;
    end else if ((controlstate == CS_RUN) && adcValid) begin
      case (state_q)
        ARMED: begin
          prev_sample_d = adcIn;
          prev_valid_d  = 1'b1;
          if (trig_fire) begin
            dp_d[0] = adcIn;
            count_d = 4'd1;
            decim_d = '0;
            state_d = FILL;
          end
        end
        FILL: begin
          if (decim_q == DECIM_LAST) begin
            dp_d[count_q[2:0]] = adcIn;
            count_d            = count_q + 4'd1;
            decim_d            = '0;
            if (count_q == 4'd7) begin
              state_d = DONE;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end
          end else begin
            decim_d = decim_q + 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // State and capture registers with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      dp_q          <= '{default: '0};
      count_q       <= '0;
      decim_q       <= '0;
      prev_sample_q <= '0;
      prev_valid_q  <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      dp_q          <= dp_d;
      count_q       <= count_d;
      decim_q       <= decim_d;
      prev_sample_q <= prev_sample_d;
      prev_valid_q  <= prev_valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign capDP0   = dp_q[0];
  assign capDP1   = dp_q[1];
  assign capDP2   = dp_q[2];
  assign capDP3   = dp_q[3];
  assign capDP4   = dp_q[4];
  assign capDP5   = dp_q[5];
  assign capDP6   = dp_q[6];
  assign capDP7   = dp_q[7];
  assign capCount = count_q;
  assign capBusy  = busy_q;
  assign capDone  = done_q;

endmodule

// File: doc/adc_capture.md
# adc_capture

Sample-capture block for the ADC input path, the receive-side counterpart of the DAC signal generator. Arms under the system control state, waits for an optional rising-edge level trigger, then stores eight 12-bit ADC samples, with optional decimation, into a register bank. The bank is presented as eight parallel datapoint outputs that the control logic reads back once capture is done.

## Interface
- DECIM, default 1: keep one sample out of every DECIM valid samples after the trigger sample. Legal range is 1..16.
- clk  in  1  single clock; all registers update on posedge.
- rst  in  1  asynchronous, active-high reset.
- controlstate  in  4  system control state. 4'h6 = ARM, 4'h8 = RUN, any other value = FREEZE.
- adcIn  in  12  ADC sample word, unsigned.
- adcValid  in  1  adcIn carries a new sample this cycle.
- trigEn  in  1  1 = wait for a level trigger, 0 = trigger on the first valid sample.
- trigLevel  in  12  trigger threshold, unsigned.
- capDP0..capDP7  out  12 each  captured samples in arrival order.
- capCount  out  4  number of samples stored, 0..8.
- capBusy  out  1  FSM is in ARMED or FILL.
- capDone  out  1  all 8 samples are stored.

## Operation
- FSM states: IDLE, ARMED, FILL, DONE.
- Reset (rst=1, asynchronous) sets:
  - state to IDLE;
  - capDP0..7, capCount, decimCnt and prevSample to 0;
  - prevValid, capBusy and capDone to 0.
- ARM (controlstate==4'h6), on every cycle it is held:
  - state goes to ARMED;
  - capDP0..7, capCount, decimCnt and prevValid are cleared;
  - capDone goes to 0 and capBusy to 1.
  - ARM overrides any capture in progress, which then restarts.
- FREEZE (any controlstate other than 4'h6 or 4'h8): every register holds. A capture in progress resumes when RUN returns.
- RUN (controlstate==4'h8), acting only on cycles with adcValid=1:
  - IDLE or DONE: no action; samples are ignored.
  - ARMED: the trigger fires when either:
    - trigEn=0, or
    - trigEn=1, prevValid=1, prevSample<trigLevel and adcIn>=trigLevel.
  - ARMED: every valid sample updates prevSample to adcIn and sets prevValid to 1.
  - ARMED, on trigger:
    - capDP0 takes adcIn and capCount goes to 1;
    - decimCnt goes to 0 and the FSM moves to FILL.
  - FILL, when decimCnt==DECIM-1:
    - adcIn is written to capDP[capCount];
    - capCount increments and decimCnt goes to 0.
  - FILL, otherwise: decimCnt increments.
  - FILL, on the 8th store: state goes to DONE, capDone to 1, capBusy to 0.
- Compares are unsigned, full 12-bit.
- decimCnt is 4 bits wide.
- With DECIM=1 every valid sample is stored.
- capCount never exceeds 8. No write occurs beyond capDP7.
- The first valid sample after ARM with trigEn=1 can never trigger, because prevValid=0.
- trigEn and trigLevel are sampled live on each ARMED cycle.

## Timing
- Latency: a sample accepted at edge k is visible on its capDP output and on capCount immediately after edge k.
- capDone and capBusy update on the same edge as the 8th store.
- adcValid=0 cycles are pure stalls: no state or counter changes.
- Simultaneous rst and any other input: rst wins.
- rst asserted mid-FILL clears all outputs asynchronously. The FSM stays IDLE until the next ARM.
- Leaving RUN for ARM mid-FILL clears everything on the next edge.
- Leaving RUN for FREEZE holds partial results. capCount reports the number of samples held.
- DONE persists through FREEZE and RUN until ARM or rst.

## Test plan
- **Reset:** assert rst with random inputs.
  - Required: all capDP outputs = 0, capCount=0, capBusy=0, capDone=0.
  - Required: deasserting rst in RUN with no ARM leaves everything at 0 while adcValid toggles.
- **Free-run capture (DECIM=1, trigEn=0):** ARM for 1 cycle, then RUN, with adcValid=1 carrying 0x100..0x109.
  - Required: capDP0..7 = 0x100..0x107.
  - Required: capDone=1 on the edge that stores 0x107; 0x108 and 0x109 are ignored; capCount=8.
- **Level trigger (trigEn=1, trigLevel=0x800):** feed 0x900, 0x700, 0x7F0, 0x800, 0x810, ...
  - Required: no trigger on 0x900, because it is the first sample and prevValid=0.
  - Required: trigger on 0x800 with capDP0=0x800 and capDP1=0x810.
  - Also required: the sequence 0x800, 0x800 does not trigger.
- **Decimation (DECIM=3, trigEn=0):** feed samples 0..30.
  - Required: capDP0..7 = 0, 3, 6, 9, 12, 15, 18, 21, with capDone set on sample 21.
- **Stall and freeze:** during FILL, insert adcValid=0 gaps and a 5-cycle controlstate=4'h5.
  - Required: outputs and capCount hold through both.
  - Required: after returning to RUN, the remaining samples land in the next capDP slots with no loss or duplication.
- **Abort paths:**
  - ARM at capCount=4 → all outputs 0 on the next edge, then a fresh capture fills from capDP0.
  - Asynchronous rst mid-FILL → outputs 0 without waiting for a clock edge.
